// File: rtl/avmm_burst_boundary_split.sv
// Splits AVMM read/write bursts that would cross a BOUNDARY_BYTES-aligned address
// into two legal sub-bursts. Unsplit commands pass through with no added latency.
// Read data and write data/byteenable pass straight through.
module avmm_burst_boundary_split #(
  parameter int unsigned ADDR_WIDTH       = 42,
  parameter int unsigned DATA_WIDTH       = 512,
  parameter int unsigned BURSTCOUNT_WIDTH = 5,
  parameter int unsigned BOUNDARY_BYTES   = 4096
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [ADDR_WIDTH-1:0]         src_address,
  input  logic [BURSTCOUNT_WIDTH-1:0]   src_burstcount,
  input  logic                          src_read,
  input  logic                          src_write,
  input  logic [DATA_WIDTH-1:0]         src_writedata,
  input  logic [DATA_WIDTH/8-1:0]       src_byteenable,
  output logic                          src_waitrequest,
  output logic [DATA_WIDTH-1:0]         src_readdata,
  output logic                          src_readdatavalid,
  output logic [ADDR_WIDTH-1:0]         snk_address,
  output logic [BURSTCOUNT_WIDTH-1:0]   snk_burstcount,
  output logic                          snk_read,
  output logic                          snk_write,
  output logic [DATA_WIDTH-1:0]         snk_writedata,
  output logic [DATA_WIDTH/8-1:0]       snk_byteenable,
  input  logic                          snk_waitrequest,
  input  logic [DATA_WIDTH-1:0]         snk_readdata,
  input  logic                          snk_readdatavalid
);

  localparam int unsigned BOUND_WORDS = BOUNDARY_BYTES / (DATA_WIDTH / 8);
  localparam int unsigned OFF_W       = $clog2(BOUND_WORDS);
  // Wide enough to hold BOUND_WORDS itself as well as any burstcount.
  localparam int unsigned WTB_W = (OFF_W + 1 > BURSTCOUNT_WIDTH + 1) ? OFF_W + 1
                                                                     : BURSTCOUNT_WIDTH + 1;
  localparam logic [BURSTCOUNT_WIDTH-1:0] BC_ONE = BURSTCOUNT_WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StRdSecond, StWrBurst} state_e;

  state_e                        r_state;
  logic [BURSTCOUNT_WIDTH-1:0]   r_total_left;
  logic [BURSTCOUNT_WIDTH-1:0]   r_sub_left;
  logic [ADDR_WIDTH-1:0]         r_addr2;
  logic [BURSTCOUNT_WIDTH-1:0]   r_cnt2;
  logic [ADDR_WIDTH-1:0]         r_cur_addr;
  logic [BURSTCOUNT_WIDTH-1:0]   r_cur_cnt;

  logic [OFF_W-1:0]              w_off;
  logic [WTB_W-1:0]              w_wtb;
  logic                          w_split;
  logic [BURSTCOUNT_WIDTH-1:0]   w_cnt1;
  logic [BURSTCOUNT_WIDTH-1:0]   w_cnt2;
  logic [ADDR_WIDTH-1:0]         w_addr2;
  logic [BURSTCOUNT_WIDTH-1:0]   w_first_bc;

  // Words left before the next boundary, and the two sub-burst descriptors.
  always_comb begin
    w_off      = src_address[OFF_W-1:0];
    w_wtb      = WTB_W'(BOUND_WORDS) - WTB_W'(w_off);
    w_split    = WTB_W'(src_burstcount) > w_wtb;
    // Only meaningful when splitting, where w_wtb < burstcount fits the narrow width.
    w_cnt1     = w_wtb[BURSTCOUNT_WIDTH-1:0];
    w_cnt2     = src_burstcount - w_cnt1;
    w_addr2    = src_address + ADDR_WIDTH'(w_wtb);
    w_first_bc = w_split ? w_cnt1 : src_burstcount;
  end

  assign src_readdata      = snk_readdata;
  assign src_readdatavalid = snk_readdatavalid;
  assign snk_writedata     = src_writedata;
  assign snk_byteenable    = src_byteenable;

  // Command-path outputs; reset forces the handshake quiet without waiting for a clock.
  // Plain if-tests leave snk_read/snk_write at 0 when the source strobes are X.
  always_comb begin
    snk_address     = src_address;
    snk_burstcount  = src_burstcount;
    snk_read        = 1'b0;
    snk_write       = 1'b0;
    src_waitrequest = 1'b1;
    if (reset_n) begin
      unique case (r_state)
        StIdle: begin
          src_waitrequest = snk_waitrequest;
          if (src_read) begin
            snk_burstcount = w_first_bc;
            snk_read       = 1'b1;
            // Hold the source until the second half has also been issued.
            if (w_split) src_waitrequest = 1'b1;
          end else if (src_write) begin
            snk_burstcount = w_first_bc;
            snk_write      = 1'b1;
          end
        end
        StRdSecond: begin
          snk_address     = r_addr2;
          snk_burstcount  = r_cnt2;
          snk_read        = 1'b1;
          src_waitrequest = snk_waitrequest;
        end
        StWrBurst: begin
          snk_address     = r_cur_addr;
          snk_burstcount  = r_cur_cnt;
          if (src_write) snk_write = 1'b1;
          src_waitrequest = snk_waitrequest;
        end
        default: begin
          src_waitrequest = 1'b1;
        end
      endcase
    end
  end

  // Split-tracking FSM: latches the second sub-burst and counts accepted write beats.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= StIdle;
      r_total_left <= '0;
      r_sub_left   <= '0;
      r_addr2      <= '0;
      r_cnt2       <= '0;
      r_cur_addr   <= '0;
      r_cur_cnt    <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (src_read) begin
            if (w_split && !snk_waitrequest) begin
              r_addr2 <= w_addr2;
              r_cnt2  <= w_cnt2;
              r_state <= StRdSecond;
            end
          end else if (src_write && !snk_waitrequest) begin
            r_total_left <= src_burstcount - BC_ONE;
            r_addr2      <= w_split ? w_addr2 : '0;
            r_cnt2       <= w_split ? w_cnt2 : '0;
            if (src_burstcount != BC_ONE) r_state <= StWrBurst;
            // A one-beat first half is already exhausted: start on the second half.
            if (w_split && (w_first_bc == BC_ONE)) begin
              r_cur_addr <= w_addr2;
              r_cur_cnt  <= w_cnt2;
              r_sub_left <= w_cnt2;
            end else begin
              r_cur_addr <= src_address;
              r_cur_cnt  <= w_first_bc;
              r_sub_left <= w_first_bc - BC_ONE;
            end
          end
        end
        StRdSecond: begin
          if (!snk_waitrequest) r_state <= StIdle;
        end
        StWrBurst: begin
          if (src_write && !snk_waitrequest) begin
            r_total_left <= r_total_left - BC_ONE;
            r_sub_left   <= r_sub_left - BC_ONE;
            if (r_total_left == BC_ONE) begin
              r_state <= StIdle;
            end else if (r_sub_left == BC_ONE) begin
              r_cur_addr <= r_addr2;
              r_cur_cnt  <= r_cnt2;
              r_sub_left <= r_cnt2;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_avmm_burst_boundary_split.sv
// Directed bench for avmm_burst_boundary_split (512-bit data, 64-word boundary).
module tb_avmm_burst_boundary_split;

  localparam int AW = 42;
  localparam int DW = 512;
  localparam int BW = 5;
  localparam int EW = DW / 8;

  logic          clk;
  logic          reset_n;
  logic [AW-1:0] src_address;
  logic [BW-1:0] src_burstcount;
  logic          src_read;
  logic          src_write;
  logic [DW-1:0] src_writedata;
  logic [EW-1:0] src_byteenable;
  logic          src_waitrequest;
  logic [DW-1:0] src_readdata;
  logic          src_readdatavalid;
  logic [AW-1:0] snk_address;
  logic [BW-1:0] snk_burstcount;
  logic          snk_read;
  logic          snk_write;
  logic [DW-1:0] snk_writedata;
  logic [EW-1:0] snk_byteenable;
  logic          snk_waitrequest;
  logic [DW-1:0] snk_readdata;
  logic          snk_readdatavalid;

  int n_pass  = 0;
  int n_total = 0;

  avmm_burst_boundary_split dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .src_address       (src_address),
    .src_burstcount    (src_burstcount),
    .src_read          (src_read),
    .src_write         (src_write),
    .src_writedata     (src_writedata),
    .src_byteenable    (src_byteenable),
    .src_waitrequest   (src_waitrequest),
    .src_readdata      (src_readdata),
    .src_readdatavalid (src_readdatavalid),
    .snk_address       (snk_address),
    .snk_burstcount    (snk_burstcount),
    .snk_read          (snk_read),
    .snk_write         (snk_write),
    .snk_writedata     (snk_writedata),
    .snk_byteenable    (snk_byteenable),
    .snk_waitrequest   (snk_waitrequest),
    .snk_readdata      (snk_readdata),
    .snk_readdatavalid (snk_readdatavalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [BW-1:0] bc;
    logic          rd;
    logic          wr;
    logic          sw;
    logic          chk_cmd;
    logic [AW-1:0] e_addr;
    logic [BW-1:0] e_bc;
    logic          e_rd;
    logic          e_wr;
    logic          e_sw;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic ok, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (ok === 1'b1) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // A non-accepted one-beat write must show its own address; any leftover state shows otherwise.
  task automatic idle_chk(input string nm);
    src_write       = 1'b1;
    src_address     = 42'h3F;
    src_burstcount  = 5'd1;
    snk_waitrequest = 1'b1;
    @(negedge clk);
    chk(nm, snk_write === 1'b1 && snk_read === 1'b0 && snk_address == 42'h3F &&
        snk_burstcount == 5'd1, {snk_address, snk_burstcount, snk_read, snk_write},
        {42'h3F, 5'd1, 1'b0, 1'b1});
    step();
    src_write       = 1'b0;
    snk_waitrequest = 1'b0;
  endtask

  task automatic rd_split(input string nm, input logic [AW-1:0] a, input logic [BW-1:0] bc,
                          input logic [BW-1:0] c1, input logic [AW-1:0] a2,
                          input logic [BW-1:0] c2, input int stall);
    int  acc;
    logic ok;
    acc            = 0;
    src_read       = 1'b1;
    src_address    = a;
    src_burstcount = bc;
    for (int k = 0; k <= stall; k++) begin
      snk_waitrequest = (k < stall);
      @(negedge clk);
      chk($sformatf("%s_first%0d", nm, k), snk_read === 1'b1 && snk_write === 1'b0 &&
          snk_address == a && snk_burstcount == c1 && src_waitrequest === 1'b1,
          {snk_address, snk_burstcount, src_waitrequest}, {a, c1, 1'b1});
      if (src_waitrequest === 1'b0) acc++;
      step();
    end
    for (int k = 0; k <= stall; k++) begin
      snk_waitrequest = (k < stall);
      @(negedge clk);
      chk($sformatf("%s_second%0d", nm, k), snk_read === 1'b1 && snk_write === 1'b0 &&
          snk_address == a2 && snk_burstcount == c2 && src_waitrequest === snk_waitrequest,
          {snk_address, snk_burstcount, src_waitrequest}, {a2, c2, snk_waitrequest});
      if (src_waitrequest === 1'b0) acc++;
      step();
    end
    src_read        = 1'b0;
    snk_waitrequest = 1'b0;
    chk({nm, "_accepts"}, acc == 1, 64'(acc), 64'd1);
    ok = 1'b1;
    for (int j = 0; j < int'(bc); j++) begin
      snk_readdatavalid = 1'b1;
      snk_readdata      = {16{32'hBEEF_0000 + 32'(j)}};
      #1;
      if (!(src_readdatavalid === 1'b1 && src_readdata == {16{32'hBEEF_0000 + 32'(j)}}))
        ok = 1'b0;
      step();
    end
    snk_readdatavalid = 1'b0;
    chk({nm, "_rdata"}, ok, 64'(src_readdata[31:0]), 64'hBEEF_0000 + 64'(bc) - 64'd1);
    idle_chk({nm, "_idle"});
  endtask

  task automatic wr_split(input string nm, input logic [AW-1:0] a, input logic [BW-1:0] bc,
                          input logic [BW-1:0] c1, input logic [AW-1:0] a2,
                          input logic [BW-1:0] c2, input logic [15:0] stall_mask,
                          input int gap_after);
    int beat;
    int acc;
    int guard;
    bit tried;
    logic [AW-1:0] ea;
    logic [BW-1:0] ec;
    beat  = 0;
    acc   = 0;
    guard = 0;
    tried = 1'b0;
    while (beat < int'(bc) && guard < 100) begin
      guard++;
      src_write      = 1'b1;
      // Only the first beat carries a real command; later beats drive junk.
      src_address    = (beat == 0) ? a : 42'h123;
      src_burstcount = (beat == 0) ? bc : 5'd7;
      src_writedata  = {16{32'hD000_0000 + 32'(beat)}};
      src_byteenable = 64'(beat + 1) * 64'h0101;
      snk_waitrequest = stall_mask[beat] && !tried;
      ea = (beat < int'(c1)) ? a : a2;
      ec = (beat < int'(c1)) ? c1 : c2;
      @(negedge clk);
      chk($sformatf("%s_b%0d", nm, beat), snk_write === 1'b1 && snk_read === 1'b0 &&
          snk_address == ea && snk_burstcount == ec && snk_writedata == src_writedata &&
          snk_byteenable == src_byteenable && src_waitrequest === snk_waitrequest,
          {snk_address, snk_burstcount, src_waitrequest}, {ea, ec, snk_waitrequest});
      if (snk_write === 1'b1 && !snk_waitrequest) acc++;
      step();
      if (!snk_waitrequest) begin
        if (beat == gap_after) begin
          src_write       = 1'b0;
          snk_waitrequest = 1'b0;
          @(negedge clk);
          chk({nm, "_gap"}, snk_write === 1'b0, 64'(snk_write), 64'd0);
          step();
        end
        beat++;
        tried = 1'b0;
      end else begin
        tried = 1'b1;
      end
    end
    src_write       = 1'b0;
    snk_waitrequest = 1'b0;
    chk({nm, "_beats"}, acc == int'(bc), 64'(acc), 64'(bc));
    idle_chk({nm, "_idle"});
  endtask

  initial begin
    reset_n           = 1'b0;
    src_address       = 42'h3C;
    src_burstcount    = 5'd8;
    src_read          = 1'b1;
    src_write         = 1'b0;
    src_writedata     = '0;
    src_byteenable    = '0;
    snk_waitrequest   = 1'b0;
    snk_readdata      = '0;
    snk_readdatavalid = 1'b0;

    //        addr            bc  rd wr sw cc  e_addr          e_bc e_rd e_wr e_sw
    vecs[0]  = '{42'h3C,       8,  1, 0, 1, 1, 42'h3C,        4,   1,   0,   1};
    vecs[1]  = '{42'h30,       16, 1, 0, 0, 1, 42'h30,        16,  1,   0,   0};
    vecs[2]  = '{42'h40,       16, 1, 0, 1, 1, 42'h40,        16,  1,   0,   1};
    vecs[3]  = '{42'h3F,       1,  0, 1, 0, 1, 42'h3F,        1,   0,   1,   0};
    vecs[4]  = '{42'h7E,       4,  0, 1, 1, 1, 42'h7E,        2,   0,   1,   1};
    vecs[5]  = '{42'h3F,       2,  1, 0, 1, 1, 42'h3F,        1,   1,   0,   1};
    vecs[6]  = '{42'h10,       3,  0, 0, 0, 0, 42'h0,         0,   0,   0,   0};
    vecs[7]  = '{42'h3C,       8,  1, 1, 1, 1, 42'h3C,        4,   1,   0,   1};
    vecs[8]  = '{42'h3FF_FFFF_FFFE, 4, 1, 0, 1, 1, 42'h3FF_FFFF_FFFE, 2, 1, 0, 1};
    vecs[9]  = '{42'h0,        16, 1, 0, 0, 1, 42'h0,         16,  1,   0,   0};
    vecs[10] = '{42'h30,       16, 0, 1, 1, 1, 42'h30,        16,  0,   1,   1};

    #3;
    chk("reset_quiet", snk_read === 1'b0 && snk_write === 1'b0 && src_waitrequest === 1'b1,
        {snk_read, snk_write, src_waitrequest}, 64'b001);
    src_read = 1'b0;
    step();
    reset_n = 1'b1;
    step();

    // Single-cycle command vectors; none of them leaves the idle state.
    for (int i = 0; i < NV; i++) begin
      src_address       = vecs[i].addr;
      src_burstcount    = vecs[i].bc;
      src_read          = vecs[i].rd;
      src_write         = vecs[i].wr;
      snk_waitrequest   = vecs[i].sw;
      src_writedata     = {16{32'hA500_0000 + 32'(i)}};
      src_byteenable    = 64'h1 << i;
      snk_readdata      = {16{32'hC0DE_0000 + 32'(i)}};
      snk_readdatavalid = i[0];
      @(negedge clk);
      if (vecs[i].chk_cmd)
        chk($sformatf("vec%0d_cmd", i), snk_address == vecs[i].e_addr &&
            snk_burstcount == vecs[i].e_bc && snk_read === vecs[i].e_rd &&
            snk_write === vecs[i].e_wr && src_waitrequest === vecs[i].e_sw,
            {snk_address, snk_burstcount, snk_read, snk_write, src_waitrequest},
            {vecs[i].e_addr, vecs[i].e_bc, vecs[i].e_rd, vecs[i].e_wr, vecs[i].e_sw});
      else
        chk($sformatf("vec%0d_idle", i), snk_read === 1'b0 && snk_write === 1'b0 &&
            src_waitrequest === 1'b0, {snk_read, snk_write, src_waitrequest}, 64'b000);
      chk($sformatf("vec%0d_pass", i), src_readdata == {16{32'hC0DE_0000 + 32'(i)}} &&
          src_readdatavalid === i[0] && snk_writedata == {16{32'hA500_0000 + 32'(i)}} &&
          snk_byteenable == (64'h1 << i), {src_readdata[31:0], 31'd0, src_readdatavalid},
          {32'hC0DE_0000 + 32'(i), 31'd0, i[0]});
      step();
      src_read  = 1'b0;
      src_write = 1'b0;
    end
    snk_waitrequest   = 1'b0;
    snk_readdatavalid = 1'b0;
    step();

    rd_split("rd_3c", 42'h3C, 5'd8, 5'd4, 42'h40, 5'd4, 0);
    rd_split("rd_3c_stall", 42'h3C, 5'd8, 5'd4, 42'h40, 5'd4, 3);
    rd_split("rd_wrap", 42'h3FF_FFFF_FFFE, 5'd4, 5'd2, 42'h0, 5'd2, 1);
    wr_split("wr_7e", 42'h7E, 5'd4, 5'd2, 42'h80, 5'd2, 16'h0, -1);
    wr_split("wr_7e_stall", 42'h7E, 5'd4, 5'd2, 42'h80, 5'd2, 16'b1010, 1);
    wr_split("wr_3f", 42'h3F, 5'd4, 5'd1, 42'h40, 5'd3, 16'h0, -1);
    wr_split("wr_30", 42'h30, 5'd16, 5'd16, 42'h0, 5'd0, 16'h0, -1);

    // Reset in the middle of a split write.
    src_write       = 1'b1;
    src_address     = 42'h7E;
    src_burstcount  = 5'd4;
    snk_waitrequest = 1'b0;
    step();
    src_address = 42'h123;
    step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async", snk_write === 1'b0 && src_waitrequest === 1'b1,
        {snk_write, src_waitrequest}, 64'b01);
    src_write = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    wr_split("rst_new", 42'h0, 5'd2, 5'd2, 42'h0, 5'd0, 16'h0, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got %0d want done", n_total);
    $fatal(1);
  end

endmodule
